// File: rtl/fast_mem_pkg.sv
// fast_mem_pkg - shared widths, FSM state encoding and port-vector types
// for the PDP-6 fast (flip-flop) accumulator memory.
package fast_mem_pkg;

    localparam int WORD_W = 36;
    localparam int ADDR_W = 4;
    localparam int NPORT  = 4;

    // Bit 0 is the MSB, matching the PDP-6 bus numbering.
    typedef logic [0:WORD_W-1] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [NPORT-1:0]  port_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACK    = 3'd1,
        ST_RD     = 3'd2,
        ST_WRWAIT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/fast_mem_arbiter.sv
// fast_mem_arbiter - fixed-priority one-hot grant; port 0 has the highest
// priority. Only consulted by the controller while it is idle.
module fast_mem_arbiter
    import fast_mem_pkg::*;
(
    input  port_vec_t req,
    output port_vec_t grant
);

    // Scan from the highest port down so the lowest requester is the last writer.
    always_comb begin
        grant = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_mem.sv
// fast_mem - sixteen-word, 36-bit flip-flop memory serving up to four
// PDP-6 memory-bus ports. Build macro FAST_MEM_4PORT_EN: when defined all
// four ports are served; when undefined ports 2 and 3 are never eligible
// and their outputs are tied to zero.
//
// Handshake: a port owns the memory from the edge its request is granted
// until the edge after its mc_rq_cyc drops. cmc_addr_ack and cmc_rd_rs are
// one-cycle registered pulses; mb_out is valid from the cmc_rd_rs edge and
// held until release. Dropping mc_rq_cyc before DONE aborts the access.
module fast_mem
    import fast_mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         fmc_p0_sel,   fmc_p1_sel,   fmc_p2_sel,   fmc_p3_sel,
    input  logic         mc_rq_cyc_p0, mc_rq_cyc_p1, mc_rq_cyc_p2, mc_rq_cyc_p3,
    input  logic         mc_rd_rq_p0,  mc_rd_rq_p1,  mc_rd_rq_p2,  mc_rd_rq_p3,
    input  logic         mc_wr_rq_p0,  mc_wr_rq_p1,  mc_wr_rq_p2,  mc_wr_rq_p3,
    input  logic         mc_wr_rs_p0,  mc_wr_rs_p1,  mc_wr_rs_p2,  mc_wr_rs_p3,
    input  logic [21:35] ma_p0, ma_p1, ma_p2, ma_p3,
    input  logic [18:21] sel_p0, sel_p1, sel_p2, sel_p3,
    input  logic         fmc_select_p0, fmc_select_p1, fmc_select_p2, fmc_select_p3,
    input  logic [0:35]  mb_in_p0, mb_in_p1, mb_in_p2, mb_in_p3,
    output logic         cmc_addr_ack_p0, cmc_addr_ack_p1, cmc_addr_ack_p2, cmc_addr_ack_p3,
    output logic         cmc_rd_rs_p0, cmc_rd_rs_p1, cmc_rd_rs_p2, cmc_rd_rs_p3,
    output logic [0:35]  mb_out_p0, mb_out_p1, mb_out_p2, mb_out_p3,
    output state_t       fsm_state
);

    // Per-port inputs gathered into vectors, bit N = port N.
    port_vec_t en_v, rq_cyc_v, rd_rq_v, wr_rq_v, wr_rs_v, fsel_v;
    addr_t     ma_a    [NPORT];
    word_t     mb_in_a [NPORT];
    port_vec_t elig, grant;

    state_t    state_q, state_d;
    port_vec_t memsel_q, memsel_d;
    addr_t     addr_q, addr_d;
    logic      rd_q, rd_d, wr_q, wr_d;
    logic      ack_q, ack_d, rd_rs_q, rd_rs_d;
    word_t     mb_q, mb_d;
    logic      we;

    logic      own_rq_cyc, own_wr_rs, gnt_rd, gnt_wr;
    word_t     own_mb_in;
    addr_t     gnt_addr;

    word_t     ff [0:15];

    assign en_v[1:0]      = {fmc_p1_sel, fmc_p0_sel};
    assign rq_cyc_v[1:0]  = {mc_rq_cyc_p1, mc_rq_cyc_p0};
    assign rd_rq_v[1:0]   = {mc_rd_rq_p1, mc_rd_rq_p0};
    assign wr_rq_v[1:0]   = {mc_wr_rq_p1, mc_wr_rq_p0};
    assign wr_rs_v[1:0]   = {mc_wr_rs_p1, mc_wr_rs_p0};
    assign fsel_v[1:0]    = {fmc_select_p1, fmc_select_p0};
    assign ma_a[0]        = ma_p0[32:35];
    assign ma_a[1]        = ma_p1[32:35];
    assign mb_in_a[0]     = mb_in_p0;
    assign mb_in_a[1]     = mb_in_p1;

    // Memory select and high address bits are decoded elsewhere on the bus.
    logic unused_common;
    assign unused_common = ^{sel_p0, sel_p1, sel_p2, sel_p3,
                             ma_p0[21:31], ma_p1[21:31]};

`ifdef FAST_MEM_4PORT_EN
    assign en_v[3:2]      = {fmc_p3_sel, fmc_p2_sel};
    assign rq_cyc_v[3:2]  = {mc_rq_cyc_p3, mc_rq_cyc_p2};
    assign rd_rq_v[3:2]   = {mc_rd_rq_p3, mc_rd_rq_p2};
    assign wr_rq_v[3:2]   = {mc_wr_rq_p3, mc_wr_rq_p2};
    assign wr_rs_v[3:2]   = {mc_wr_rs_p3, mc_wr_rs_p2};
    assign fsel_v[3:2]    = {fmc_select_p3, fmc_select_p2};
    assign ma_a[2]        = ma_p2[32:35];
    assign ma_a[3]        = ma_p3[32:35];
    assign mb_in_a[2]     = mb_in_p2;
    assign mb_in_a[3]     = mb_in_p3;

    logic unused_hi;
    assign unused_hi = ^{ma_p2[21:31], ma_p3[21:31]};

    assign cmc_addr_ack_p2 = ack_q & memsel_q[2];
    assign cmc_addr_ack_p3 = ack_q & memsel_q[3];
    assign cmc_rd_rs_p2    = rd_rs_q & memsel_q[2];
    assign cmc_rd_rs_p3    = rd_rs_q & memsel_q[3];
    assign mb_out_p2       = mb_q & {WORD_W{memsel_q[2]}};
    assign mb_out_p3       = mb_q & {WORD_W{memsel_q[3]}};
`else
    assign en_v[3:2]      = '0;
    assign rq_cyc_v[3:2]  = '0;
    assign rd_rq_v[3:2]   = '0;
    assign wr_rq_v[3:2]   = '0;
    assign wr_rs_v[3:2]   = '0;
    assign fsel_v[3:2]    = '0;
    assign ma_a[2]        = '0;
    assign ma_a[3]        = '0;
    assign mb_in_a[2]     = '0;
    assign mb_in_a[3]     = '0;

    logic unused_hi;
    assign unused_hi = ^{fmc_p2_sel, fmc_p3_sel, mc_rq_cyc_p2, mc_rq_cyc_p3,
                         mc_rd_rq_p2, mc_rd_rq_p3, mc_wr_rq_p2, mc_wr_rq_p3,
                         mc_wr_rs_p2, mc_wr_rs_p3, ma_p2, ma_p3,
                         fmc_select_p2, fmc_select_p3, mb_in_p2, mb_in_p3};

    assign cmc_addr_ack_p2 = 1'b0;
    assign cmc_addr_ack_p3 = 1'b0;
    assign cmc_rd_rs_p2    = 1'b0;
    assign cmc_rd_rs_p3    = 1'b0;
    assign mb_out_p2       = '0;
    assign mb_out_p3       = '0;
`endif

    assign cmc_addr_ack_p0 = ack_q & memsel_q[0];
    assign cmc_addr_ack_p1 = ack_q & memsel_q[1];
    assign cmc_rd_rs_p0    = rd_rs_q & memsel_q[0];
    assign cmc_rd_rs_p1    = rd_rs_q & memsel_q[1];
    assign mb_out_p0       = mb_q & {WORD_W{memsel_q[0]}};
    assign mb_out_p1       = mb_q & {WORD_W{memsel_q[1]}};
    assign fsm_state       = state_q;

    assign elig = en_v & rq_cyc_v & fsel_v & (rd_rq_v | wr_rq_v);

    fast_mem_arbiter u_arb (
        .req   (elig),
        .grant (grant)
    );

    // Select the owning port's live signals and the winner's request fields.
    always_comb begin
        own_rq_cyc = |(rq_cyc_v & memsel_q);
        own_wr_rs  = |(wr_rs_v & memsel_q);
        own_mb_in  = '0;
        gnt_addr   = '0;
        gnt_rd     = 1'b0;
        gnt_wr     = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (memsel_q[i]) own_mb_in = own_mb_in | mb_in_a[i];
            if (grant[i]) begin
                gnt_addr = ma_a[i];
                gnt_rd   = rd_rq_v[i];
                gnt_wr   = wr_rq_v[i];
            end
        end
    end

    // Next state and next registered outputs; an early rq_cyc drop aborts.
    always_comb begin
        state_d  = state_q;
        memsel_d = memsel_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        ack_d    = 1'b0;
        rd_rs_d  = 1'b0;
        mb_d     = mb_q;
        we       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    state_d  = ST_ACK;
                    memsel_d = grant;
                    addr_d   = gnt_addr;
                    rd_d     = gnt_rd;
                    wr_d     = gnt_wr;
                end
            end
            ST_ACK, ST_RD, ST_WRWAIT: begin
                if (!own_rq_cyc) begin
                    state_d  = ST_IDLE;
                    memsel_d = '0;
                    mb_d     = '0;
                end else if (state_q == ST_ACK) begin
                    ack_d   = 1'b1;
                    state_d = rd_q ? ST_RD : ST_WRWAIT;
                end else if (state_q == ST_RD) begin
                    rd_rs_d = 1'b1;
                    mb_d    = ff[addr_q];
                    state_d = wr_q ? ST_WRWAIT : ST_DONE;
                end else if (own_wr_rs) begin
                    we      = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!own_rq_cyc) begin
                    state_d  = ST_IDLE;
                    memsel_d = '0;
                    mb_d     = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                memsel_d = '0;
                mb_d     = '0;
            end
        endcase
    end

    // Control registers; reset returns to idle with every output low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            memsel_q <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack_q    <= 1'b0;
            rd_rs_q  <= 1'b0;
            mb_q     <= '0;
        end else begin
            state_q  <= state_d;
            memsel_q <= memsel_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ack_q    <= ack_d;
            rd_rs_q  <= rd_rs_d;
            mb_q     <= mb_d;
        end
    end

    // Storage is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (we && !reset) ff[addr_q] <= own_mb_in;
    end

endmodule

// File: tb/tb_fast_mem.sv
// tb_fast_mem - self-checking bench for fast_mem. Expected read data comes
// from a word-array model of the memory; expected handshake timing comes
// from the bus timing rules (ack one cycle after the request edge, read
// restart one cycle later, release one cycle after rq_cyc drops).
module tb_fast_mem;
    import fast_mem_pkg::*;

`ifdef FAST_MEM_4PORT_EN
    localparam int NP = 4;
`else
    localparam int NP = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fmc_sel [4];
    logic        rq_cyc  [4];
    logic        rd_rq   [4];
    logic        wr_rq   [4];
    logic        wr_rs   [4];
    logic        fsel    [4];
    logic [21:35] ma     [4];
    logic [18:21] sel    [4];
    logic [0:35] mb_in   [4];
    logic        addr_ack[4];
    logic        rd_rs   [4];
    logic [0:35] mb_out  [4];
    state_t      fsm_state;

    word_t       model_mem [16];
    logic [35:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    fast_mem dut (
        .clk(clk), .reset(reset),
        .fmc_p0_sel(fmc_sel[0]), .fmc_p1_sel(fmc_sel[1]), .fmc_p2_sel(fmc_sel[2]), .fmc_p3_sel(fmc_sel[3]),
        .mc_rq_cyc_p0(rq_cyc[0]), .mc_rq_cyc_p1(rq_cyc[1]), .mc_rq_cyc_p2(rq_cyc[2]), .mc_rq_cyc_p3(rq_cyc[3]),
        .mc_rd_rq_p0(rd_rq[0]), .mc_rd_rq_p1(rd_rq[1]), .mc_rd_rq_p2(rd_rq[2]), .mc_rd_rq_p3(rd_rq[3]),
        .mc_wr_rq_p0(wr_rq[0]), .mc_wr_rq_p1(wr_rq[1]), .mc_wr_rq_p2(wr_rq[2]), .mc_wr_rq_p3(wr_rq[3]),
        .mc_wr_rs_p0(wr_rs[0]), .mc_wr_rs_p1(wr_rs[1]), .mc_wr_rs_p2(wr_rs[2]), .mc_wr_rs_p3(wr_rs[3]),
        .ma_p0(ma[0]), .ma_p1(ma[1]), .ma_p2(ma[2]), .ma_p3(ma[3]),
        .sel_p0(sel[0]), .sel_p1(sel[1]), .sel_p2(sel[2]), .sel_p3(sel[3]),
        .fmc_select_p0(fsel[0]), .fmc_select_p1(fsel[1]), .fmc_select_p2(fsel[2]), .fmc_select_p3(fsel[3]),
        .mb_in_p0(mb_in[0]), .mb_in_p1(mb_in[1]), .mb_in_p2(mb_in[2]), .mb_in_p3(mb_in[3]),
        .cmc_addr_ack_p0(addr_ack[0]), .cmc_addr_ack_p1(addr_ack[1]),
        .cmc_addr_ack_p2(addr_ack[2]), .cmc_addr_ack_p3(addr_ack[3]),
        .cmc_rd_rs_p0(rd_rs[0]), .cmc_rd_rs_p1(rd_rs[1]), .cmc_rd_rs_p2(rd_rs[2]), .cmc_rd_rs_p3(rd_rs[3]),
        .mb_out_p0(mb_out[0]), .mb_out_p1(mb_out[1]), .mb_out_p2(mb_out[2]), .mb_out_p3(mb_out[3]),
        .fsm_state(fsm_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic release_port(input int p);
        rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0; wr_rq[p] = 1'b0;
        wr_rs[p]  = 1'b0; fsel[p]  = 1'b0; fmc_sel[p] = 1'b0;
    endtask

    task automatic raise_req(input int p, input logic [3:0] a, input bit rd, input bit wr);
        fmc_sel[p] = 1'b1; fsel[p] = 1'b1; rq_cyc[p] = 1'b1;
        rd_rq[p] = rd; wr_rq[p] = wr;
        ma[p] = {11'($urandom), a};
        sel[p] = 4'($urandom);
        mb_in[p] = 36'({$urandom, $urandom});
    endtask

    function automatic bit others_quiet(input int p);
        bit q_ok = 1'b1;
        for (int q = 0; q < 4; q++)
            if (q != p && (addr_ack[q] !== 1'b0 || rd_rs[q] !== 1'b0 || mb_out[q] !== '0)) q_ok = 1'b0;
        return q_ok;
    endfunction

    // One complete bus access as a processor would run it; records what it saw.
    task automatic access(input int p, input logic [3:0] a, input bit rd, input bit wr, input word_t wd,
                          output int ack_at, output int ack_len, output int rs_at, output int rs_len,
                          output word_t rdata, output bit held, output bit other_nz, output bit cleared);
        bit wrs_up = 1'b0;
        ack_at = -1; ack_len = 0; rs_at = -1; rs_len = 0;
        rdata = '0; held = 1'b1; other_nz = 1'b0;
        @(negedge clk);
        raise_req(p, a, rd, wr);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (addr_ack[p] === 1'b1) begin
                if (ack_at < 0) ack_at = j;
                ack_len++;
            end
            if (rd_rs[p] === 1'b1) begin
                if (rs_at < 0) begin rs_at = j; rdata = mb_out[p]; end
                rs_len++;
            end
            if (rs_at >= 0 && mb_out[p] !== rdata) held = 1'b0;
            if (!others_quiet(p)) other_nz = 1'b1;
            if (wr && ack_at >= 0 && !wrs_up) begin
                wr_rs[p] = 1'b1; mb_in[p] = wd; wrs_up = 1'b1;
            end
        end
        release_port(p);
        @(negedge clk);
        cleared = (mb_out[p] === '0) && (addr_ack[p] === 1'b0) && (rd_rs[p] === 1'b0);
    endtask

    // Two ports raise read requests together; hi should win, lo follows.
    task automatic contend(input int hi, input int lo, input logic [3:0] a_hi, input logic [3:0] a_lo,
                           output int hi_ack_at, output bit lo_early, output int lo_ack_k, output word_t lo_data);
        hi_ack_at = -1; lo_early = 1'b0; lo_ack_k = -1; lo_data = '0;
        @(negedge clk);
        raise_req(hi, a_hi, 1'b1, 1'b0);
        raise_req(lo, a_lo, 1'b1, 1'b0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (addr_ack[hi] === 1'b1 && hi_ack_at < 0) hi_ack_at = j;
            if (addr_ack[lo] !== 1'b0 || rd_rs[lo] !== 1'b0 || mb_out[lo] !== '0) lo_early = 1'b1;
        end
        release_port(hi);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (addr_ack[lo] === 1'b1 && lo_ack_k < 0) lo_ack_k = k;
            if (rd_rs[lo] === 1'b1) lo_data = mb_out[lo];
        end
        release_port(lo);
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit quiet = 1'b1;
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            release_port(p); ma[p] = '0; sel[p] = '0; mb_in[p] = '0;
        end
        repeat (3) @(negedge clk);
        raise_req(0, 4'd2, 1'b1, 1'b0);   // request while reset is held: reset wins
        repeat (3) begin
            @(negedge clk);
            if (!others_quiet(-1)) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++; $display("FAIL reset_wins: a port output was nonzero under reset, need all 0");
        end
        n_tests++;
        if (fsm_state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: fsm_state=%0d need %0d", fsm_state, ST_IDLE);
        end
        release_port(0);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (!others_quiet(-1)) begin
            n_fail++; $display("FAIL reset_outputs: outputs nonzero after reset, need all 0");
        end
    endtask

    task automatic test_preload();
        int ack_at, ack_len, rs_at, rs_len; word_t rdata; bit held, onz, clr;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 36'o050000 | 36'(i + 1);
            access(i % 2, 4'(i), 1'b0, 1'b1, model_mem[i], ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
            n_tests++;
            if (ack_at !== 1 || ack_len !== 1 || rs_at !== -1 || onz || !clr) begin
                n_fail++;
                $display("FAIL preload_write[%0d]: ack_at=%0d ack_len=%0d rs_at=%0d others=%0b cleared=%0b need 1 1 -1 0 1",
                         i, ack_at, ack_len, rs_at, onz, clr);
            end
        end
    endtask

    task automatic test_read();
        int ack_at, ack_len, rs_at, rs_len; word_t rdata; bit held, onz, clr;
        access(0, 4'd4, 1'b1, 1'b0, '0, ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
        n_tests++;
        if (ack_at !== 1 || ack_len !== 1) begin
            n_fail++; $display("FAIL read_ack: at=%0d len=%0d need at=1 len=1", ack_at, ack_len);
        end
        n_tests++;
        if (rs_at !== 2 || rs_len !== 1) begin
            n_fail++; $display("FAIL read_rs: at=%0d len=%0d need at=2 len=1", rs_at, rs_len);
        end
        n_tests++;
        if (rdata !== 36'o050005) begin
            n_fail++; $display("FAIL read_data: got %o need %o", rdata, 36'o050005);
        end
        n_tests++;
        if (!held || !clr || onz) begin
            n_fail++; $display("FAIL read_hold_release: held=%0b cleared=%0b others=%0b need 1 1 0", held, clr, onz);
        end
    endtask

    task automatic test_write_read();
        int ack_at, ack_len, rs_at, rs_len; word_t rdata; bit held, onz, clr;
        access(0, 4'd4, 1'b0, 1'b1, 36'o123456654321, ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
        model_mem[4] = 36'o123456654321;
        access(1, 4'd4, 1'b1, 1'b0, '0, ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
        n_tests++;
        if (rdata !== 36'o123456654321 || rs_at !== 2) begin
            n_fail++; $display("FAIL write_read4: got %o at %0d need %o at 2", rdata, rs_at, 36'o123456654321);
        end
        access(0, 4'd5, 1'b1, 1'b0, '0, ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
        n_tests++;
        if (rdata !== 36'o050006) begin
            n_fail++; $display("FAIL neighbour5: got %o need %o", rdata, 36'o050006);
        end
    endtask

    task automatic test_rpw();
        int ack_at, ack_len, rs_at, rs_len; word_t rdata; bit held, onz, clr;
        access(0, 4'h3, 1'b1, 1'b1, 36'o777777000000, ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
        n_tests++;
        if (rdata !== 36'o050004 || rs_at !== 2 || ack_at !== 1 || !clr) begin
            n_fail++; $display("FAIL rpw_read: got %o rs_at=%0d ack_at=%0d cleared=%0b need %o 2 1 1",
                               rdata, rs_at, ack_at, clr, 36'o050004);
        end
        model_mem[3] = 36'o777777000000;
        access(1, 4'h3, 1'b1, 1'b0, '0, ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
        n_tests++;
        if (rdata !== 36'o777777000000) begin
            n_fail++; $display("FAIL rpw_written: got %o need %o", rdata, 36'o777777000000);
        end
    endtask

    task automatic test_not_selected();
        for (int v = 0; v < 2; v++) begin
            bit seen = 1'b0;
            @(negedge clk);
            raise_req(0, 4'd4, 1'b1, 1'b0);
            if (v == 0) fsel[0] = 1'b0; else fmc_sel[0] = 1'b0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                if (addr_ack[0] !== 1'b0 || rd_rs[0] !== 1'b0 || mb_out[0] !== '0) seen = 1'b1;
            end
            release_port(0);
            @(negedge clk);
            n_tests++;
            if (seen) begin
                n_fail++; $display("FAIL not_selected[%0d]: port 0 responded, need silence", v);
            end
        end
    endtask

    task automatic test_priority();
        int hi_at, lo_k; bit lo_early; word_t lo_data;
        contend(1, 3, 4'd9, 4'd12, hi_at, lo_early, lo_k, lo_data);
        n_tests++;
        if (hi_at !== 1 || lo_early) begin
            n_fail++; $display("FAIL prio_p1_first: p1 ack_at=%0d p3_early=%0b need 1 0", hi_at, lo_early);
        end
`ifdef FAST_MEM_4PORT_EN
        n_tests++;
        if (lo_k !== 3 || lo_data !== model_mem[12]) begin
            n_fail++; $display("FAIL prio_p3_after: ack_k=%0d data=%o need 3 %o", lo_k, lo_data, model_mem[12]);
        end
`else
        n_tests++;
        if (lo_k !== -1 || lo_data !== '0) begin
            n_fail++; $display("FAIL prio_p3_disabled: ack_k=%0d data=%o need -1 0", lo_k, lo_data);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int hi_at, lo_k; bit lo_early; word_t lo_data;
        contend(0, 1, 4'd0, 4'd15, hi_at, lo_early, lo_k, lo_data);
        n_tests++;
        if (hi_at !== 1 || lo_early || lo_k !== 3 || lo_data !== model_mem[15]) begin
            n_fail++; $display("FAIL turnaround: p0_at=%0d p1_early=%0b p1_k=%0d data=%o need 1 0 3 %o",
                               hi_at, lo_early, lo_k, lo_data, model_mem[15]);
        end
    endtask

    task automatic test_reset_mid_write();
        int ack_at, ack_len, rs_at, rs_len; word_t rdata; bit held, onz, clr;
        bit quiet = 1'b1; bit ack1;
        @(negedge clk);
        raise_req(0, 4'd7, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        ack1 = addr_ack[0];
        reset = 1'b1;                                 // lands in WRWAIT together with wr_rs
        wr_rs[0] = 1'b1; mb_in[0] = 36'o707070707070;
        @(negedge clk);
        reset = 1'b0; rq_cyc[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (!others_quiet(-1)) quiet = 1'b0;
            @(negedge clk);
        end
        release_port(0);
        n_tests++;
        if (ack1 !== 1'b1 || !quiet) begin
            n_fail++; $display("FAIL reset_mid_write: ack=%0b quiet=%0b need 1 1", ack1, quiet);
        end
        access(0, 4'd7, 1'b1, 1'b0, '0, ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
        n_tests++;
        if (rdata !== model_mem[7] || ack_at !== 1 || rs_at !== 2) begin
            n_fail++; $display("FAIL reset_mid_write_mem: got %o ack_at=%0d rs_at=%0d need %o 1 2",
                               rdata, ack_at, rs_at, model_mem[7]);
        end
    endtask

    task automatic test_random();
        int ack_at, ack_len, rs_at, rs_len; word_t rdata; bit held, onz, clr;
        for (int n = 0; n < 24; n++) begin
            int p = $urandom_range(0, NP - 1);
            logic [3:0] a = 4'($urandom_range(0, 15));
            int op = $urandom_range(0, 2);        // 0 read, 1 write, 2 read-pause-write
            word_t wd = 36'({$urandom, $urandom});
            bit rd = (op != 1);
            bit wr = (op != 0);
            if (rd) exp_q.push_back(model_mem[a]);
            access(p, a, rd, wr, wd, ack_at, ack_len, rs_at, rs_len, rdata, held, onz, clr);
            if (wr) model_mem[a] = wd;
            n_tests++;
            if (ack_at !== 1 || ack_len !== 1 || onz || !clr) begin
                n_fail++; $display("FAIL rand_proto[%0d]: p%0d ack_at=%0d len=%0d others=%0b cleared=%0b need 1 1 0 1",
                                   n, p, ack_at, ack_len, onz, clr);
            end
            if (rd) begin
                logic [35:0] exp = exp_q.pop_front();
                n_tests++;
                if (rdata !== exp || rs_at !== 2 || rs_len !== 1) begin
                    n_fail++; $display("FAIL rand_read[%0d]: p%0d a=%0d got %o rs_at=%0d len=%0d need %o 2 1",
                                       n, p, a, rdata, rs_at, rs_len, exp);
                end
            end else begin
                n_tests++;
                if (rs_at !== -1) begin
                    n_fail++; $display("FAIL rand_write_rs[%0d]: rd_rs at %0d need none", n, rs_at);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_preload();
        test_read();
        test_write_read();
        test_rpw();
        test_not_selected();
        test_priority();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fast_mem.md
# fast_mem

Sixteen-word, 36-bit fast (flip-flop) accumulator memory on the PDP-6 memory bus. It serves up to four processor ports, each with its own request/acknowledge handshake. It answers only requests flagged with `fmc_select`; core memory answers the rest. It sits beside the core memory module, and its read data is OR-ed onto each port's shared data bus.

## Interface
- No parameters. Word width 36 (bits 0:35, bit 0 MSB); address 4 bits.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; see Operation.
- Per port, N = 0..3:
  - `fmc_pN_sel`  in  1  port enable switch.
  - `mc_rq_cyc_pN`  in  1  request cycle, held for the whole cycle.
  - `mc_rd_rq_pN`  in  1  read request.
  - `mc_wr_rq_pN`  in  1  write request.
  - `mc_wr_rs_pN`  in  1  write restart; data valid on `mb_in_pN`.
  - `ma_pN`  in  [21:35]  address; bits 32:35 used.
  - `sel_pN`  in  [18:21]  memory select; ignored by this block.
  - `fmc_select_pN`  in  1  request targets fast memory.
  - `mb_in_pN`  in  [0:35]  write data.
  - `cmc_addr_ack_pN`  out  1  address acknowledge.
  - `cmc_rd_rs_pN`  out  1  read restart (data valid).
  - `mb_out_pN`  out  [0:35]  read data; all zero when not driving.

## Operation
- Storage `ff[0:15]` is 36 bits per word. Reset does not clear it.
- Eligible request on port N: `fmc_pN_sel & mc_rq_cyc_pN & fmc_select_pN & (mc_rd_rq_pN | mc_wr_rq_pN)`.
- Arbitration happens in IDLE only. The lowest-numbered eligible port wins. Losers wait; nothing is dropped.
- The winning port is latched in one-hot `memsel_p0..p3`. Address `ma[32:35]`, rd flag and wr flag are latched too.
- FSM states: IDLE → ACK → RD (if rd) → WRWAIT (if wr) → DONE → IDLE.
- **ACK:** `cmc_addr_ack` = 1 for exactly one cycle.
- **Read (RD):**
  - `mb_out` = `ff[addr]` from this state onward.
  - `cmc_rd_rs` = 1 for one cycle.
  - Without wr: go to DONE.
  - With wr (read-pause-write): go to WRWAIT.
- **Write-only:** ACK goes straight to WRWAIT.
- **WRWAIT:** on the `mc_wr_rs` edge, `ff[addr] <= mb_in`, then go to DONE.
- **DONE:**
  - Hold `mb_out` (read-only cycles) until `mc_rq_cyc` of the owning port drops.
  - Then clear `memsel` and `mb_out`, and go to IDLE.
- `mc_rq_cyc` drops before the handshake completes (abort): go to IDLE immediately, no write, outputs to 0.
- Only the owning port's outputs are ever nonzero. All other ports' outputs stay 0.
- Reset:
  - FSM → IDLE; `memsel` cleared.
  - All `cmc_*` = 0; all `mb_out` = 0.
  - Applies mid-cycle too, with any pending write discarded.

## Timing
- Request sampled at edge T; `cmc_addr_ack` is high during T+1..T+2.
- Read: `mb_out` valid from edge T+2. `cmc_rd_rs` is high during T+2..T+3.
- Write: data is captured at the first edge where `mc_wr_rs` = 1 in WRWAIT. A read in the same cycle of the next access sees the new value.
- Minimum turnaround: a new request is accepted the cycle after IDLE is re-entered.
- Simultaneous request and reset: reset wins.

## Configuration
- `FAST_MEM_4PORT_EN` defined: all four ports functional.
- Undefined:
  - Ports 2 and 3 are never eligible.
  - Their outputs are tied to 0.
  - Their inputs are unused.
  - Ports 0 and 1 behave identically in both builds.

## Structure
- Package `fast_mem_pkg`:
  - `WORD_W` = 36, `ADDR_W` = 4, `NPORT` = 4.
  - FSM state enum.
  - Port-vector typedefs.
- Sub-module `fast_mem_arbiter`: fixed-priority one-hot grant from eligible vector, used only in IDLE.
- Top: FSM, latched address/flags, storage array, per-port output gating.

## Test plan
- **Read:** preload `ff[i] = (i+1) | 36'o50000`. Port 0 reads `ma` = 4 with `fmc_select` = 1 → one-cycle ack, then `cmc_rd_rs` pulse, `mb_out_p0` = 36'o050005, returning to 0 after `mc_rq_cyc` drops.
- **Write then read:** write `36'o123456654321` to address 4 via `mc_wr_rs` → a subsequent read of 4 returns `36'o123456654321`; `ff[5]` unchanged (36'o050006).
- **Read-pause-write:** rd+wr on address 0x3 → `mb_out` = 36'o050004 with `cmc_rd_rs`; after `wr_rs` with data 36'o777777000000, `ff[3]` = 36'o777777000000.
- **Not selected:** `fmc_select_p0` = 0, or `fmc_p0_sel` = 0 → no ack ever, `mb_out_p0` stays 0.
- **Priority:** ports 1 and 3 request in the same cycle → port 1 acknowledged first, port 3 acknowledged after port 1's `rq_cyc` drops. Without `FAST_MEM_4PORT_EN`, port 3 is never acknowledged.
- **Reset mid-write:** `reset` pulsed in WRWAIT, then `wr_rs` → outputs 0, memory word unchanged, next request served normally.
